jtag_scan_seq: RTL and testbench
================================

# jtag_scan_seq

Host-side scan sequencer for the debug module's JTAG TAP. It accepts IR-scan or DR-scan requests of up to MAXLEN bits and walks `tap_fsm` through Select/Capture/Shift/Exit1/Update by driving `tms`, shifting `tdi` out LSB-first and collecting `tdo`. After reset it forces the TAP into Test-Logic-Reset, then parks it in Run-Test/Idle. It sits between the debug-transport logic (DMI access generator, bench drivers) and `tap_fsm`, which is clocked by the same `clk`.

## Interface
Parameters:
- MAXLEN, 41: maximum scan length in bits (DMI: 7 addr + 32 data + 2 op).
- TLR_CYCLES, 5: consecutive tms=1 cycles used to force Test-Logic-Reset.

Ports:
- clk  in  1  single clock, shared with tap_fsm.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  scan request present.
- req_ready  out  1  sequencer idle and able to accept.
- req_ir  in  1  1 = IR scan, 0 = DR scan.
- req_len  in  $clog2(MAXLEN+1)  bits to shift.
- req_data  in  MAXLEN  shift-in data, bit 0 shifted first.
- tlr_req  in  1  request a TLR re-sync; sampled in IDLE only.
- rsp_valid  out  1  one-cycle pulse: scan complete.
- rsp_data  out  MAXLEN  captured tdo bits, bit i = i-th bit shifted out; held until next accept.
- tms  out  1  to tap_fsm.
- tdi  out  1  to TAP data input.
- tdo  in  1  from TAP serial output.

## Operation
- Internal state mirrors the TAP state. tms and tdi are Moore outputs of the registered state and are stable for the whole cycle.
- States, with tms value, then next state:
  - TLR: tms=1; counter runs 0..TLR_CYCLES-1, then IDLE.
  - IDLE (TAP Run-Test/Idle): tms=0, req_ready=1. Accept (req_valid&&req_ready) latches ir, len, data and goes to START. If there is no accept and tlr_req=1, go to TLR with the counter cleared. A simultaneous accept and tlr_req: the accept wins and tlr_req is dropped.
  - START (TAP still RTI): tms=1, then SEL_DR.
  - SEL_DR: tms=ir. Next is SEL_IR if ir, else CAPTURE.
  - SEL_IR: tms=0, then CAPTURE.
  - CAPTURE: tms=0, then SHIFT; bit counter cleared.
  - SHIFT: tdi=data[cnt]; tms=(cnt==len-1). Each edge writes rsp_data[cnt]<=tdo and increments cnt. Moves to EXIT1 after the last bit.
  - EXIT1: tms=1, then UPDATE.
  - UPDATE: tms=0, rsp_valid=1, then IDLE.
- tdi=0 in every state other than SHIFT.
- Length rules:
  - req_len=0 is treated as 1.
  - req_len>MAXLEN is clamped to MAXLEN.
  - The counter is $clog2(MAXLEN+1) bits wide and never wraps.
- rsp_data bits at index ≥ len are cleared on accept.
- req_ready is 0 in every state except IDLE; requests outside IDLE are ignored, not queued.

## Timing
- Reset values:
  - state=TLR, counter=0.
  - tms=1, tdi=0.
  - req_ready=0, rsp_valid=0, rsp_data=0.
- The first req_ready=1 occurs TLR_CYCLES cycles after reset deassertion.
- DR scan of N bits: rsp_valid is asserted in the (N+4)th cycle after the accept edge; req_ready returns on the next cycle.
- IR scan of N bits: rsp_valid is asserted in cycle N+5; req_ready returns on the next cycle.
- tdo is sampled on the rising edge that ends each SHIFT cycle.
- Reset mid-scan: the scan is aborted at once with no rsp_valid, the outputs take their reset values, and the TLR sequence reruns.

## Structure
- dm_pkg holds:
  - `seq_state_t` enum (TLR, IDLE, START, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE).
  - `DMI_WIDTH=41`.
  - `TLR_CYCLES_DEF=5`.
- No sub-module. The FSM, length counter and data/capture registers live in one module. tap_fsm is instantiated only in the bench, alongside a TDR/IR loopback model.

## Test plan
- **Post-reset TLR sequence.** Reset released at 41 ns → tms=1 for exactly 5 cycles. Then tms=0, req_ready=1, and tap_fsm run_test_idle=1.
- **8-bit DR scan.** req_ir=0, len=8, data=0xA5, with a bench TDR preloaded to 0x3C → tms stream 1,0,0,0×7,1,1,0.
  - tdi stream is 1,0,1,0,0,1,0,1.
  - rsp_data[7:0]=0x3C, rsp_valid in cycle 12.
  - tap_fsm update_dr asserts in the same cycle as rsp_valid.
- **5-bit IR scan.** req_ir=1, len=5, data=0x11 → tms stream 1,1,0,0,0×4,1,1,0.
  - IR model holds 0x11 and returns 0x01 (the IR capture value).
  - rsp_valid in cycle 10.
- **Length boundaries.**
  - len=0 → exactly 1 SHIFT cycle.
  - len=60 → 41 SHIFT cycles.
  - len=41 with data all-ones → rsp_data=tdo pattern across all 41 bits.
- **Back-to-back and ignored requests.**
  - req_valid held high → the second accept occurs exactly 1 cycle after rsp_valid.
  - req_valid pulsed during SHIFT is ignored.
  - tlr_req together with req_valid in IDLE → scan proceeds and no TLR occurs.
- **Reset mid-SHIFT.** Reset asserted mid-SHIFT (cnt=3 of 8) → tms=1 and rsp_valid=0 immediately, with no spurious rsp_valid. TLR reruns and the next scan completes correctly.

Source files
------------

// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_pkg
// Brief    : Shared types and constants for the debug-module JTAG host side.
// Revision : 1.0 - initial release
// ============================================================================
package dm_pkg;

    localparam int DMI_WIDTH      = 41;
    localparam int TLR_CYCLES_DEF = 5;

    // Sequencer states; each one mirrors the TAP state the TAP is in that cycle.
    typedef enum logic [3:0] {
        TLR     = 4'd0,
        IDLE    = 4'd1,
        START   = 4'd2,
        SEL_DR  = 4'd3,
        SEL_IR  = 4'd4,
        CAPTURE = 4'd5,
        SHIFT   = 4'd6,
        EXIT1   = 4'd7,
        UPDATE  = 4'd8
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/jtag_scan_seq.sv
`default_nettype none
// ============================================================================
// Module   : jtag_scan_seq
// Brief    : Host-side IR/DR scan sequencer driving tms/tdi into a JTAG TAP.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_scan_seq
    import dm_pkg::*;
#(
    parameter int MAXLEN     = DMI_WIDTH,
    parameter int TLR_CYCLES = TLR_CYCLES_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_ir,
    input  logic [$clog2(MAXLEN+1)-1:0]    req_len,
    input  logic [MAXLEN-1:0]              req_data,
    input  logic                           tlr_req,
    output logic                           rsp_valid,
    output logic [MAXLEN-1:0]              rsp_data,
    output logic                           tms,
    output logic                           tdi,
    input  logic                           tdo
);

    localparam int                 c_len_w    = $clog2(MAXLEN + 1);
    localparam logic [c_len_w-1:0] c_one      = c_len_w'(1);
    localparam logic [c_len_w-1:0] c_max_len  = c_len_w'(MAXLEN);
    localparam logic [c_len_w-1:0] c_tlr_last = c_len_w'(TLR_CYCLES - 1);

    seq_state_t          r_state;
    seq_state_t          w_next;
    logic [c_len_w-1:0]  r_cnt;
    logic [c_len_w-1:0]  r_len;
    logic                r_ir;
    logic [MAXLEN-1:0]   r_data;
    logic [MAXLEN-1:0]   r_rsp;
    logic [c_len_w-1:0]  w_len_eff;
    logic [MAXLEN-1:0]   w_keep;
    logic                w_accept;
    logic                w_last;

    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_last   = (r_cnt == r_len - c_one);
    assign rsp_data = r_rsp;

    // Zero-length requests still shift one bit; oversize ones are clamped.
    always_comb begin
        w_len_eff = req_len;
        if (req_len == '0) begin
            w_len_eff = c_one;
        end else if (req_len > c_max_len) begin
            w_len_eff = c_max_len;
        end
        for (int i = 0; i < MAXLEN; i++) begin
            w_keep[i] = (i < int'(w_len_eff));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= TLR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        tms       = 1'b0;
        tdi       = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            TLR: begin
                tms = 1'b1;
                if (r_cnt == c_tlr_last) w_next = IDLE;
            end
            IDLE: begin
                req_ready = 1'b1;
                if (w_accept)     w_next = START;
                else if (tlr_req) w_next = TLR;
            end
            START: begin
                tms    = 1'b1;
                w_next = SEL_DR;
            end
            SEL_DR: begin
                tms    = r_ir;
                w_next = r_ir ? SEL_IR : CAPTURE;
            end
            SEL_IR:  w_next = CAPTURE;
            CAPTURE: w_next = SHIFT;
            SHIFT: begin
                tdi = r_data[r_cnt];
                tms = w_last;
                if (w_last) w_next = EXIT1;
            end
            EXIT1: begin
                tms    = 1'b1;
                w_next = UPDATE;
            end
            UPDATE: begin
                rsp_valid = 1'b1;
                w_next    = IDLE;
            end
            default: begin
                tms    = 1'b1;
                w_next = TLR;
            end
        endcase
    end

    // r_cnt doubles as the TLR dwell counter and the shift bit index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_len  <= '0;
            r_ir   <= 1'b0;
            r_data <= '0;
            r_rsp  <= '0;
        end else begin
            case (r_state)
                TLR: r_cnt <= (r_cnt == c_tlr_last) ? '0 : r_cnt + c_one;
                IDLE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        r_ir   <= req_ir;
                        r_len  <= w_len_eff;
                        r_data <= req_data;
                        r_rsp  <= r_rsp & w_keep;
                    end
                end
                CAPTURE: r_cnt <= '0;
                SHIFT: begin
                    r_rsp[r_cnt] <= tdo;
                    r_cnt        <= r_cnt + c_one;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_scan_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_scan_seq
// Brief    : Directed bench for jtag_scan_seq with a behavioural TAP + IR/TDR.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_scan_seq;

    localparam int MAXLEN = 41;
    localparam int LW     = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ir = 1'b0;
    logic              tlr_req = 1'b0;
    logic [LW-1:0]     req_len = '0;
    logic [MAXLEN-1:0] req_data = '0;
    logic              req_ready, rsp_valid, tms, tdi, tdo;
    logic [MAXLEN-1:0] rsp_data;

    int errors = 0;
    int checks = 0;

    jtag_scan_seq #(.MAXLEN(MAXLEN), .TLR_CYCLES(5)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_ir(req_ir), .req_len(req_len), .req_data(req_data), .tlr_req(tlr_req),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;

    // Behavioural TAP controller, 5-bit IR and a 41-bit test data register.
    localparam logic [3:0] T_TLR = 4'd0, T_RTI = 4'd1, T_SELDR = 4'd2, T_CAPDR = 4'd3,
                           T_SHDR = 4'd4, T_EX1DR = 4'd5, T_PDR = 4'd6, T_EX2DR = 4'd7,
                           T_UPDDR = 4'd8, T_SELIR = 4'd9, T_CAPIR = 4'd10, T_SHIR = 4'd11,
                           T_EX1IR = 4'd12, T_PIR = 4'd13, T_EX2IR = 4'd14, T_UPDIR = 4'd15;
    logic [3:0]        tap_st = T_SHIR;
    logic [MAXLEN-1:0] tdr_cap = '0, dr_sr = '0, dr_upd = '0;
    logic [4:0]        ir_sr = '0, ir_reg = '0;
    logic              run_test_idle, update_dr;

    assign run_test_idle = (tap_st == T_RTI);
    assign update_dr     = (tap_st == T_UPDDR);
    assign tdo = (tap_st == T_SHDR) ? dr_sr[0] : (tap_st == T_SHIR) ? ir_sr[0] : 1'b0;

    always @(posedge clk) begin
        case (tap_st)
            T_TLR:   tap_st <= tms ? T_TLR   : T_RTI;
            T_RTI:   tap_st <= tms ? T_SELDR : T_RTI;
            T_SELDR: tap_st <= tms ? T_SELIR : T_CAPDR;
            T_CAPDR: tap_st <= tms ? T_EX1DR : T_SHDR;
            T_SHDR:  tap_st <= tms ? T_EX1DR : T_SHDR;
            T_EX1DR: tap_st <= tms ? T_UPDDR : T_PDR;
            T_PDR:   tap_st <= tms ? T_EX2DR : T_PDR;
            T_EX2DR: tap_st <= tms ? T_UPDDR : T_SHDR;
            T_UPDDR: tap_st <= tms ? T_SELDR : T_RTI;
            T_SELIR: tap_st <= tms ? T_TLR   : T_CAPIR;
            T_CAPIR: tap_st <= tms ? T_EX1IR : T_SHIR;
            T_SHIR:  tap_st <= tms ? T_EX1IR : T_SHIR;
            T_EX1IR: tap_st <= tms ? T_UPDIR : T_PIR;
            T_PIR:   tap_st <= tms ? T_EX2IR : T_PIR;
            T_EX2IR: tap_st <= tms ? T_UPDIR : T_SHIR;
            default: tap_st <= tms ? T_SELDR : T_RTI;
        endcase
        if (tap_st == T_CAPDR) dr_sr  <= tdr_cap;
        if (tap_st == T_SHDR)  dr_sr  <= {tdi, dr_sr[MAXLEN-1:1]};
        if (tap_st == T_UPDDR) dr_upd <= dr_sr;
        if (tap_st == T_CAPIR) ir_sr  <= 5'b00001;
        if (tap_st == T_SHIR)  ir_sr  <= {tdi, ir_sr[4:1]};
        if (tap_st == T_UPDIR) ir_reg <= ir_sr;
    end

    // Issues one request; cycle index 0 is the cycle right after the accept edge.
    task automatic do_scan(input logic ir, input logic [LW-1:0] len, input logic [MAXLEN-1:0] data,
                           input int pulse_idx, input logic with_tlr,
                           output logic [63:0] tms_s, output logic [63:0] tdi_s, output int vcyc,
                           output logic [MAXLEN-1:0] rsp, output int nshift,
                           output logic upd_v, output logic rdy_after);
        int w;
        tms_s = '0; tdi_s = '0; vcyc = -1; rsp = '0; nshift = 0; upd_v = 1'b0; rdy_after = 1'b0;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        req_ir = ir; req_len = len; req_data = data; req_valid = 1'b1; tlr_req = with_tlr;
        for (int idx = 0; idx < 64; idx++) begin
            @(negedge clk);
            tlr_req   = 1'b0;
            req_valid = (idx == pulse_idx);
            if (idx == pulse_idx) req_data = ~data;
            tms_s[idx] = tms;
            tdi_s[idx] = tdi;
            if (vcyc >= 0) begin
                rdy_after = req_ready;
                break;
            end
            if (tap_st == T_SHDR || tap_st == T_SHIR) nshift++;
            if (rsp_valid) begin
                vcyc  = idx;
                rsp   = rsp_data;
                upd_v = update_dr;
            end
        end
    endtask

    logic [63:0]       t_tms, t_tdi;
    int                t_v, t_ns;
    logic [MAXLEN-1:0] t_rsp;
    logic              t_upd, t_rdy;

    task automatic test_reset();
        int first, bad;
        reset = 1'b1;
        #20;
        checks++; if (tms !== 1'b1)       begin errors++; $display("FAIL rst_tms got %b exp 1", tms); end
        checks++; if (tdi !== 1'b0)       begin errors++; $display("FAIL rst_tdi got %b exp 0", tdi); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_data !== '0)    begin errors++; $display("FAIL rst_rsp got %h exp 0", rsp_data); end
        #21;
        reset = 1'b0;
        first = -1; bad = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (req_ready) begin
                first = k;
                break;
            end
            if (tms !== 1'b1) bad++;
        end
        checks++; if (first != 5) begin errors++; $display("FAIL tlr_len got %0d exp 5", first); end
        checks++; if (bad != 0)   begin errors++; $display("FAIL tlr_tms got %0d zero cycles exp 0", bad); end
        checks++; if (tms !== 1'b0) begin errors++; $display("FAIL idle_tms got %b exp 0", tms); end
        @(posedge clk); #1;
        checks++; if (run_test_idle !== 1'b1) begin errors++; $display("FAIL tap_rti got %b exp 1", run_test_idle); end
    endtask

    task automatic test_dr_scan();
        tdr_cap = 41'h3C;
        do_scan(1'b0, 6'd8, 41'hA5, -1, 1'b0, t_tms, t_tdi, t_v, t_rsp, t_ns, t_upd, t_rdy);
        checks++; if (t_tms[12:0] !== 13'h0C01) begin errors++; $display("FAIL dr8_tms got %h exp 0c01", t_tms[12:0]); end
        checks++; if (t_tdi[12:0] !== 13'h0528) begin errors++; $display("FAIL dr8_tdi got %h exp 0528", t_tdi[12:0]); end
        checks++; if (t_v != 12)                begin errors++; $display("FAIL dr8_vcyc got %0d exp 12", t_v); end
        checks++; if (t_rsp !== 41'h3C)         begin errors++; $display("FAIL dr8_rsp got %h exp 3c", t_rsp); end
        checks++; if (t_upd !== 1'b1)           begin errors++; $display("FAIL dr8_upd got %b exp 1", t_upd); end
        checks++; if (t_rdy !== 1'b1)           begin errors++; $display("FAIL dr8_ready got %b exp 1", t_rdy); end
        checks++; if (t_ns != 8)                begin errors++; $display("FAIL dr8_nshift got %0d exp 8", t_ns); end
    endtask

    task automatic test_ir_scan();
        do_scan(1'b1, 6'd5, 41'h11, -1, 1'b0, t_tms, t_tdi, t_v, t_rsp, t_ns, t_upd, t_rdy);
        checks++; if (t_tms[10:0] !== 11'h303) begin errors++; $display("FAIL ir5_tms got %h exp 303", t_tms[10:0]); end
        checks++; if (t_tdi[10:0] !== 11'h110) begin errors++; $display("FAIL ir5_tdi got %h exp 110", t_tdi[10:0]); end
        checks++; if (t_v != 10)               begin errors++; $display("FAIL ir5_vcyc got %0d exp 10", t_v); end
        checks++; if (t_rsp !== 41'h01)        begin errors++; $display("FAIL ir5_rsp got %h exp 01", t_rsp); end
        checks++; if (ir_reg !== 5'h11)        begin errors++; $display("FAIL ir5_reg got %h exp 11", ir_reg); end
    endtask

    task automatic test_len_bounds();
        tdr_cap = 41'h1A5C3F00FF1;
        do_scan(1'b0, 6'd41, 41'h1FFFFFFFFFF, -1, 1'b0, t_tms, t_tdi, t_v, t_rsp, t_ns, t_upd, t_rdy);
        checks++; if (t_rsp !== 41'h1A5C3F00FF1) begin errors++; $display("FAIL len41_rsp got %h exp 1a5c3f00ff1", t_rsp); end
        checks++; if (dr_upd !== 41'h1FFFFFFFFFF) begin errors++; $display("FAIL len41_upd got %h exp 1ffffffffff", dr_upd); end
        checks++; if (t_ns != 41)                 begin errors++; $display("FAIL len41_nshift got %0d exp 41", t_ns); end
        do_scan(1'b0, 6'd0, 41'h1, -1, 1'b0, t_tms, t_tdi, t_v, t_rsp, t_ns, t_upd, t_rdy);
        checks++; if (t_ns != 1)              begin errors++; $display("FAIL len0_nshift got %0d exp 1", t_ns); end
        checks++; if (t_v != 5)               begin errors++; $display("FAIL len0_vcyc got %0d exp 5", t_v); end
        checks++; if (t_rsp !== 41'h1)        begin errors++; $display("FAIL len0_rsp got %h exp 1", t_rsp); end
        checks++; if (t_tdi[5:0] !== 6'h08)   begin errors++; $display("FAIL len0_tdi got %h exp 08", t_tdi[5:0]); end
        do_scan(1'b0, 6'd60, 41'h0, -1, 1'b0, t_tms, t_tdi, t_v, t_rsp, t_ns, t_upd, t_rdy);
        checks++; if (t_ns != 41)                 begin errors++; $display("FAIL len60_nshift got %0d exp 41", t_ns); end
        checks++; if (t_v != 45)                  begin errors++; $display("FAIL len60_vcyc got %0d exp 45", t_v); end
        checks++; if (t_rsp !== 41'h1A5C3F00FF1)  begin errors++; $display("FAIL len60_rsp got %h exp 1a5c3f00ff1", t_rsp); end
    endtask

    task automatic test_back_to_back();
        int v1, v2, w;
        logic rdy1, tms2, rdy2;
        logic [MAXLEN-1:0] rsp1, rsp2;
        v1 = -1; v2 = -1; rdy1 = 1'b0; tms2 = 1'b0; rdy2 = 1'b1; rsp1 = '0; rsp2 = '0;
        tdr_cap = 41'h6;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        req_ir = 1'b0; req_len = 6'd4; req_data = 41'h9; req_valid = 1'b1;
        for (int idx = 0; idx < 40; idx++) begin
            @(negedge clk);
            if (v1 < 0) begin
                if (rsp_valid) begin
                    v1 = idx;
                    rsp1 = rsp_data;
                end
            end else if (idx == v1 + 1) begin
                rdy1 = req_ready;
            end else if (idx == v1 + 2) begin
                tms2 = tms;
                rdy2 = req_ready;
                req_valid = 1'b0;
            end else if (rsp_valid) begin
                v2 = idx;
                rsp2 = rsp_data;
                break;
            end
        end
        req_valid = 1'b0;
        checks++; if (v1 != 8)          begin errors++; $display("FAIL b2b_v1 got %0d exp 8", v1); end
        checks++; if (rsp1 !== 41'h6)   begin errors++; $display("FAIL b2b_rsp1 got %h exp 6", rsp1); end
        checks++; if (rdy1 !== 1'b1)    begin errors++; $display("FAIL b2b_ready got %b exp 1", rdy1); end
        checks++; if (tms2 !== 1'b1 || rdy2 !== 1'b0) begin errors++; $display("FAIL b2b_start got tms=%b rdy=%b exp tms=1 rdy=0", tms2, rdy2); end
        checks++; if (v2 != 18)         begin errors++; $display("FAIL b2b_v2 got %0d exp 18", v2); end
        checks++; if (rsp2 !== 41'h6)   begin errors++; $display("FAIL b2b_rsp2 got %h exp 6", rsp2); end
    endtask

    task automatic test_ignored_req();
        tdr_cap = 41'h3C;
        do_scan(1'b0, 6'd8, 41'hA5, 5, 1'b0, t_tms, t_tdi, t_v, t_rsp, t_ns, t_upd, t_rdy);
        checks++; if (t_tdi[12:0] !== 13'h0528) begin errors++; $display("FAIL ign_tdi got %h exp 0528", t_tdi[12:0]); end
        checks++; if (t_v != 12)                begin errors++; $display("FAIL ign_vcyc got %0d exp 12", t_v); end
        checks++; if (t_rsp !== 41'h3C)         begin errors++; $display("FAIL ign_rsp got %h exp 3c", t_rsp); end
        @(negedge clk); @(negedge clk);
        checks++; if (req_ready !== 1'b1 || tms !== 1'b0) begin errors++; $display("FAIL ign_queued got rdy=%b tms=%b exp rdy=1 tms=0", req_ready, tms); end
    endtask

    task automatic test_tlr_conflict();
        int k;
        tdr_cap = 41'h3C;
        do_scan(1'b0, 6'd8, 41'hA5, -1, 1'b1, t_tms, t_tdi, t_v, t_rsp, t_ns, t_upd, t_rdy);
        checks++; if (t_tms[12:0] !== 13'h0C01) begin errors++; $display("FAIL tlrc_tms got %h exp 0c01", t_tms[12:0]); end
        checks++; if (t_v != 12)                begin errors++; $display("FAIL tlrc_vcyc got %0d exp 12", t_v); end
        checks++; if (t_rdy !== 1'b1)           begin errors++; $display("FAIL tlrc_ready got %b exp 1", t_rdy); end
        tlr_req = 1'b1;
        @(negedge clk);
        tlr_req = 1'b0;
        checks++; if (tms !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL tlr_enter got tms=%b rdy=%b exp tms=1 rdy=0", tms, req_ready); end
        k = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                k = i;
                break;
            end
        end
        checks++; if (k != 5) begin errors++; $display("FAIL tlr_reentry got %0d exp 5", k); end
    endtask

    task automatic test_reset_mid_shift();
        int spurious, k, w;
        spurious = 0; k = -1; w = 0;
        tdr_cap = 41'h3C;
        @(negedge clk);
        while (!req_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        req_ir = 1'b0; req_len = 6'd8; req_data = 41'hA5; req_valid = 1'b1;
        for (int idx = 0; idx <= 6; idx++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) spurious++;
        end
        reset = 1'b1;
        #1;
        checks++; if (tms !== 1'b1)       begin errors++; $display("FAIL mid_tms got %b exp 1", tms); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", rsp_valid); end
        checks++; if (req_ready !== 1'b0 || tdi !== 1'b0 || rsp_data !== '0)
            begin errors++; $display("FAIL mid_outs got rdy=%b tdi=%b rsp=%h exp 0/0/0", req_ready, tdi, rsp_data); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (rsp_valid) spurious++;
        end
        reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_valid) spurious++;
            if (req_ready) begin
                k = i;
                break;
            end
        end
        checks++; if (k != 5)        begin errors++; $display("FAIL mid_tlr got %0d exp 5", k); end
        checks++; if (spurious != 0) begin errors++; $display("FAIL mid_spurious got %0d exp 0", spurious); end
        do_scan(1'b0, 6'd8, 41'hA5, -1, 1'b0, t_tms, t_tdi, t_v, t_rsp, t_ns, t_upd, t_rdy);
        checks++; if (t_rsp !== 41'h3C) begin errors++; $display("FAIL mid_rescan_rsp got %h exp 3c", t_rsp); end
        checks++; if (t_v != 12)        begin errors++; $display("FAIL mid_rescan_vcyc got %0d exp 12", t_v); end
    endtask

    initial begin
        test_reset();
        test_dr_scan();
        test_ir_scan();
        test_len_bounds();
        test_back_to_back();
        test_ignored_req();
        test_tlr_conflict();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
